// File: rtl/logicnets_stream_pkg.sv
// +----------------------------------------------------------------------+
// | logicnets_stream_pkg: shared constants and types for the input       |
// | feature stream feeding the first LUT-neuron layer.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package logicnets_stream_pkg;

  localparam int c_IN_BITS = 2;
  localparam int c_NUM_IN  = 48;

  // A one-feature frame still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [0:0] {
    FILL = 1'b0,
    DROP = 1'b1
  } pack_state_e;

endpackage

`default_nettype wire

// File: rtl/layer_input_packer.sv
// +----------------------------------------------------------------------+
// | layer_input_packer: packs NUM_IN quantized features into one frame,  |
// | checks frame boundaries and buffers one frame toward the layer.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module layer_input_packer
  import logicnets_stream_pkg::*;
#(
  parameter  int IN_BITS = c_IN_BITS,
  parameter  int NUM_IN  = c_NUM_IN,
  localparam int OUT_W   = IN_BITS * NUM_IN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [IN_BITS-1:0] s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic               err_short,
  output logic               err_long
);

  localparam int                IDX_W    = idx_width(NUM_IN);
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_IN - 1);

  if (NUM_IN < 1) begin : g_bad_num_in
    $error("layer_input_packer: NUM_IN must be at least 1");
  end

  pack_state_e      r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [OUT_W-1:0] r_asm, w_asm_nxt;
  logic             r_asm_full, w_asm_full_nxt;
  logic [OUT_W-1:0] r_m_data, w_m_data_nxt;
  logic             r_m_valid, w_m_valid_nxt;
  logic             r_err_short, w_err_short_nxt;
  logic             r_err_long, w_err_long_nxt;

  logic             w_s_ready;
  logic             w_accept;
  logic             w_out_free;
  logic [OUT_W-1:0] w_frame;

  assign w_s_ready  = !r_asm_full;
  assign w_accept   = s_valid && w_s_ready;
  assign w_out_free = !r_m_valid || m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FILL;
      r_idx       <= '0;
      r_asm       <= '0;
      r_asm_full  <= 1'b0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_asm       <= w_asm_nxt;
      r_asm_full  <= w_asm_full_nxt;
      r_m_data    <= w_m_data_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_err_short <= w_err_short_nxt;
      r_err_long  <= w_err_long_nxt;
    end
  end

  always_comb begin
    w_frame                           = r_asm;
    w_frame[r_idx*IN_BITS +: IN_BITS] = s_data;

    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_asm_nxt       = r_asm;
    w_asm_full_nxt  = r_asm_full;
    w_m_data_nxt    = r_m_data;
    w_m_valid_nxt   = r_m_valid;
    w_err_short_nxt = 1'b0;
    w_err_long_nxt  = 1'b0;

    if (r_m_valid && m_ready) begin
      w_m_valid_nxt = 1'b0;
    end

    // A held frame blocks input, so this never collides with a completing beat.
    if (r_asm_full && w_out_free) begin
      w_m_data_nxt   = r_asm;
      w_m_valid_nxt  = 1'b1;
      w_asm_full_nxt = 1'b0;
    end

    if (w_accept) begin
      case (r_state)
        FILL: begin
          if (r_idx == c_IDX_LAST) begin
            w_idx_nxt = '0;
            if (w_out_free) begin
              w_m_data_nxt  = w_frame;
              w_m_valid_nxt = 1'b1;
            end else begin
              w_asm_nxt      = w_frame;
              w_asm_full_nxt = 1'b1;
            end
            if (!s_last) begin
              w_err_long_nxt = 1'b1;
              w_state_nxt    = DROP;
            end
          end else if (s_last) begin
            w_err_short_nxt = 1'b1;
            w_idx_nxt       = '0;
          end else begin
            w_asm_nxt = w_frame;
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
        DROP: begin
          if (s_last) begin
            w_state_nxt = FILL;
            w_idx_nxt   = '0;
          end
        end
        default: w_state_nxt = FILL;
      endcase
    end
  end

  assign s_ready   = w_s_ready;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign err_short = r_err_short;
  assign err_long  = r_err_long;

endmodule

`default_nettype wire

// File: tb/tb_layer_input_packer.sv
// +----------------------------------------------------------------------+
// | tb_layer_input_packer: directed scoreboard bench for the packer      |
// | with NUM_IN=4, IN_BITS=2.                                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_layer_input_packer;

  localparam int IN_BITS = 2;
  localparam int NUM_IN  = 4;
  localparam int OUT_W   = IN_BITS * NUM_IN;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [IN_BITS-1:0] s_data = '0;
  logic               s_last = 1'b0;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic [OUT_W-1:0]   m_data;
  logic               err_short;
  logic               err_long;

  always #5 clk = ~clk;

  layer_input_packer #(
    .IN_BITS(IN_BITS),
    .NUM_IN (NUM_IN)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .err_short(err_short),
    .err_long (err_long)
  );

  int errors = 0;
  int checks = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] exp_frame;
  int n_push = 0;
  int n_pop = 0;
  int n_short = 0;
  int n_long = 0;
  int n_sready_low = 0;
  bit t5_active = 1'b0;
  logic prev_hold = 1'b0;
  logic [OUT_W-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks hold stability.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_frame: observed=%0h expected=none", m_data);
        end else begin
          exp_frame = exp_q.pop_front();
          check("frame", 32'(m_data), 32'(exp_frame));
          n_pop++;
        end
      end
      if (err_short) n_short++;
      if (err_long) n_long++;
      if (t5_active && !s_ready) n_sready_low++;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic push_exp(input logic [OUT_W-1:0] f);
    exp_q.push_back(f);
    n_push++;
  endtask

  task automatic send_beat(input logic [IN_BITS-1:0] d, input logic l);
    int w = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $error("FAIL s_ready_timeout: observed=0 expected=1");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [OUT_W-1:0] f, input bit push);
    if (push) push_exp(f);
    for (int k = 0; k < NUM_IN; k++) begin
      send_beat(f[k*IN_BITS +: IN_BITS], k == NUM_IN - 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_err_short", 32'(err_short), 32'd0);
    check("rst_err_long", 32'(err_long), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", 32'(s_ready), 32'd1);
    idle(1);

    // 1: single frame, one-cycle latency
    push_exp(8'b00111001);
    send_beat(2'd1, 1'b0);
    send_beat(2'd2, 1'b0);
    send_beat(2'd3, 1'b0);
    s_valid = 1'b1;
    s_data  = 2'd0;
    s_last  = 1'b1;
    @(negedge clk);
    check("t1_valid_before", 32'(m_valid), 32'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("t1_valid_after", 32'(m_valid), 32'd1);
    check("t1_data", 32'(m_data), 32'h39);
    idle(2);

    // 2: backpressure, two frames held in order
    m_ready = 1'b0;
    send_frame(8'b00111001, 1'b1);
    send_frame(8'b11000110, 1'b1);
    check("t2_s_ready_low", 32'(s_ready), 32'd0);
    check("t2_m_valid", 32'(m_valid), 32'd1);
    check("t2_m_data", 32'(m_data), 32'h39);
    idle(3);
    m_ready = 1'b1;
    idle(3);
    check("t2_pops", 32'(n_pop), 32'd3);
    check("t2_s_ready_back", 32'(s_ready), 32'd1);
    check("t2_m_valid_drained", 32'(m_valid), 32'd0);

    // 3: short frame
    send_beat(2'd1, 1'b0);
    send_beat(2'd2, 1'b1);
    check("t3_err_short", 32'(err_short), 32'd1);
    check("t3_no_valid", 32'(m_valid), 32'd0);
    idle(1);
    check("t3_err_short_pulse", 32'(err_short), 32'd0);
    send_frame(8'b11000000, 1'b1);
    idle(2);
    check("t3_short_count", 32'(n_short), 32'd1);

    // 4: long frame, tail dropped
    push_exp(8'b01010101);
    send_beat(2'd1, 1'b0);
    send_beat(2'd1, 1'b0);
    send_beat(2'd1, 1'b0);
    send_beat(2'd1, 1'b0);
    check("t4_m_valid", 32'(m_valid), 32'd1);
    check("t4_m_data", 32'(m_data), 32'h55);
    check("t4_err_long", 32'(err_long), 32'd1);
    send_beat(2'd2, 1'b0);
    send_beat(2'd2, 1'b1);
    send_frame(8'h1B, 1'b1);
    idle(2);
    check("t4_long_count", 32'(n_long), 32'd1);
    check("t4_short_count", 32'(n_short), 32'd1);

    // 5: 100 random frames at full rate
    t5_active = 1'b1;
    for (int f = 0; f < 100; f++) begin
      send_frame(OUT_W'($urandom), 1'b1);
    end
    t5_active = 1'b0;
    idle(3);
    check("t5_s_ready_never_low", 32'(n_sready_low), 32'd0);
    check("t5_all_delivered", 32'(n_pop), 32'(n_push));

    // 6: reset mid-frame with a held output frame
    m_ready = 1'b0;
    send_frame(8'hE4, 1'b0);
    send_beat(2'd3, 1'b0);
    send_beat(2'd3, 1'b0);
    check("t6_held_valid", 32'(m_valid), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_m_valid", 32'(m_valid), 32'd0);
    check("t6_rst_m_data", 32'(m_data), 32'd0);
    check("t6_rst_err_short", 32'(err_short), 32'd0);
    check("t6_rst_err_long", 32'(err_long), 32'd0);
    idle(2);
    rst = 1'b1;
    m_ready = 1'b1;
    idle(1);
    send_frame(8'h9C, 1'b1);
    check("t6_first_frame", 32'(m_data), 32'h9C);
    idle(3);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_pop_count", 32'(n_pop), 32'(n_push));
    check("final_long_count", 32'(n_long), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
